// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, constants and pointer sizing for the buffered fetch stage.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int PC_INC = 4;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            pred_taken;
  } fetch_entry_t;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: reservation FIFO with separate alloc, fill and read pointers (wrap bit included).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DW = 32,
  parameter int DEPTH = 4,
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          alloc,
  input  logic [DW-1:0] alloc_pc,
  input  logic          alloc_pred,
  input  logic          fill,
  input  logic [DW-1:0] fill_data,
  input  logic          pop,
  output logic          full,
  output logic [PW-1:0] inflight,
  output logic          head_valid,
  output logic [DW-1:0] head_pc,
  output logic [DW-1:0] head_instr,
  output logic          head_pred
);
  localparam int IW = PW - 1;
  logic [PW-1:0] alloc_ptr, fill_ptr, rd_ptr;
  logic [DW-1:0] pc_mem [DEPTH];
  logic [DW-1:0] instr_mem [DEPTH];
  logic          pred_mem [DEPTH];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      alloc_ptr <= '0;
      fill_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      alloc_ptr <= alloc_ptr + PW'(alloc);
      fill_ptr <= fill_ptr + PW'(fill);
      rd_ptr <= rd_ptr + PW'(pop);
    end
  always_ff @(posedge clk) begin
    if (alloc) begin
      pc_mem[alloc_ptr[IW-1:0]] <= alloc_pc;
      pred_mem[alloc_ptr[IW-1:0]] <= alloc_pred;
    end
    if (fill) instr_mem[fill_ptr[IW-1:0]] <= fill_data;
  end
  assign full = (alloc_ptr - rd_ptr) == PW'(DEPTH);
  assign inflight = alloc_ptr - fill_ptr;
  assign head_valid = fill_ptr != rd_ptr;
  // Head fields read zero while empty so stale slots never leak to decode.
  assign head_pc = head_valid ? pc_mem[rd_ptr[IW-1:0]] : '0;
  assign head_instr = head_valid ? instr_mem[rd_ptr[IW-1:0]] : '0;
  assign head_pred = head_valid && pred_mem[rd_ptr[IW-1:0]];
endmodule

// File: rtl/fetch_buffered.sv
// fetch_buffered: decoupled fetch stage with prefetch queue, prediction steering and redirect drop tracking.
module fetch_buffered
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  input  logic                  predict_valid,
  input  logic                  predict_taken,
  input  logic [DATA_WIDTH-1:0] predict_target,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] pc_out4,
  output logic                  pred_taken_out
);
  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam int SW = PW + 1;
  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [PW-1:0] drop_cnt, inflight;
  logic [SW-1:0] drop_sum;
  logic full, accept, taken, fill, pop;
  assign imem_req_valid = rst && fetch_en && !redirect && !full && drop_cnt != PW'(FIFO_DEPTH);
  assign imem_req_addr = fetch_pc;
  assign accept = imem_req_valid && imem_req_ready;
  assign taken = predict_valid && predict_taken;
  assign fill = imem_rsp_valid && drop_cnt == '0 && !redirect;
  assign pop = out_valid && out_ready && !redirect;
  // Responses still owed for flushed slots, plus any already owed, must be discarded later.
  assign drop_sum = {1'b0, drop_cnt} + {1'b0, inflight};
  assign pc_out4 = out_valid ? pc_out + DATA_WIDTH'(PC_INC) : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      fetch_pc <= redirect ? redirect_target :
                  accept ? (taken ? predict_target : fetch_pc + DATA_WIDTH'(PC_INC)) : fetch_pc;
      drop_cnt <= redirect ? ((imem_rsp_valid && drop_sum == '0) ? '0 : PW'(drop_sum - SW'(imem_rsp_valid))) :
                  (imem_rsp_valid && drop_cnt != '0) ? drop_cnt - PW'(1) : drop_cnt;
    end
  fetch_queue #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_queue (
    .clk(clk),
    .rst(rst),
    .flush(redirect),
    .alloc(accept),
    .alloc_pc(fetch_pc),
    .alloc_pred(taken),
    .fill(fill),
    .fill_data(imem_rsp_data),
    .pop(pop),
    .full(full),
    .inflight(inflight),
    .head_valid(out_valid),
    .head_pc(pc_out),
    .head_instr(Instr),
    .head_pred(pred_taken_out)
  );
endmodule

// File: tb/tb_fetch_buffered.sv
// tb_fetch_buffered: directed scenarios with an in-order memory model and an output scoreboard.
module tb_fetch_buffered;
  import fetch_pkg::*;
  localparam int DW = 32;
  logic clk = 0, rst = 1, fetch_en = 0, redirect = 0, predict_valid = 0, predict_taken = 0;
  logic imem_req_ready = 0, imem_rsp_valid = 0, out_ready = 0;
  logic [DW-1:0] redirect_target = '0, predict_target = '0, imem_rsp_data = '0;
  logic imem_req_valid, out_valid, pred_taken_out;
  logic [DW-1:0] imem_req_addr, Instr, pc_out, pc_out4;

  always #5 clk = ~clk;

  fetch_buffered #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_target(redirect_target), .predict_valid(predict_valid),
    .predict_taken(predict_taken), .predict_target(predict_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
    .Instr(Instr), .pc_out(pc_out), .pc_out4(pc_out4), .pred_taken_out(pred_taken_out)
  );

  typedef struct {
    logic [DW-1:0] addr;
    int            due;
  } mreq_t;
  mreq_t memq[$];
  fetch_entry_t sb[$];
  fetch_entry_t mon_e;
  logic [DW-1:0] acc[$];
  logic [DW-1:0] model_pc = '0;
  int n_cmp = 0, n_bad = 0, cyc = 0, lat = 1;

  function automatic logic [DW-1:0] mem_f(input logic [DW-1:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One cycle starting at a falling edge: drive the memory response, log acceptance, wait.
  task automatic step();
    imem_rsp_valid = memq.size() > 0 && memq[0].due <= cyc;
    imem_rsp_data = imem_rsp_valid ? mem_f(memq[0].addr) : '0;
    #1;
    if (imem_rsp_valid) void'(memq.pop_front());
    if (imem_req_valid && imem_req_ready) begin
      acc.push_back(imem_req_addr);
      memq.push_back('{imem_req_addr, cyc + lat});
      sb.push_back('{model_pc, mem_f(model_pc), predict_valid && predict_taken});
      model_pc = (predict_valid && predict_taken) ? predict_target : model_pc + 32'd4;
    end
    if (redirect) begin
      sb.delete();
      model_pc = redirect_target;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    check("rst_req_valid", DW'(imem_req_valid), 0);
    check("rst_out_valid", DW'(out_valid), 0);
    check("rst_instr", Instr, 0);
    check("rst_pc_out", pc_out, 0);
    check("rst_pc_out4", pc_out4, 0);
    check("rst_pred", DW'(pred_taken_out), 0);
    memq.delete();
    sb.delete();
    acc.delete();
    model_pc = '0;
    fetch_en = 0;
    redirect = 0;
    predict_valid = 0;
    predict_taken = 0;
    imem_req_ready = 1;
    out_ready = 1;
    imem_rsp_valid = 0;
    lat = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    cyc = 0;
  endtask

  always @(negedge clk) begin
    #2;
    if (rst && out_valid && out_ready && !redirect) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL out_unexpected: got pc %h want no output", pc_out);
      end else begin
        mon_e = sb.pop_front();
        check("out_pc", pc_out, mon_e.pc);
        check("out_pc4", pc_out4, mon_e.pc + 32'd4);
        check("out_instr", Instr, mon_e.instr);
        check("out_pred", DW'(pred_taken_out), DW'(mon_e.pred_taken));
      end
    end
  end

  initial begin
    #2;
    do_reset();
    fetch_en = 1;
    step();
    check("lat_c1_empty", DW'(out_valid), 0);
    step();
    check("lat_c2_valid", DW'(out_valid), 1);
    check("lat_c2_pc", pc_out, 32'h0);
    run(4);
    fetch_en = 0;
    run(4);
    check("basic_accepts", DW'(acc.size()), 6);
    check("basic_drained", DW'(out_valid), 0);

    do_reset();
    out_ready = 0;
    fetch_en = 1;
    run(8);
    check("bp_accepts", DW'(acc.size()), 4);
    check("bp_req_blocked", DW'(imem_req_valid), 0);
    check("bp_head_valid", DW'(out_valid), 1);
    out_ready = 1;
    run(4);
    check("bp_resume_addr", acc[4], 32'h10);
    fetch_en = 0;
    run(5);

    do_reset();
    lat = 3;
    fetch_en = 1;
    run(4);
    redirect = 1;
    redirect_target = 32'h100;
    run(1);
    redirect = 0;
    check("rd_drop_two", DW'(u_dut.drop_cnt), 2);
    run(2);
    check("rd_drop_zero", DW'(u_dut.drop_cnt), 0);
    run(2);
    check("rd_first_valid", DW'(out_valid), 1);
    check("rd_first_pc", pc_out, 32'h100);
    fetch_en = 0;
    run(10);

    do_reset();
    fetch_en = 1;
    run(4);
    predict_valid = 1;
    predict_taken = 1;
    predict_target = 32'h40;
    run(1);
    predict_valid = 0;
    predict_taken = 0;
    run(3);
    fetch_en = 0;
    run(4);
    check("pred_src_addr", acc[4], 32'h10);
    check("pred_tgt_addr", acc[5], 32'h40);
    check("pred_next_addr", acc[6], 32'h44);

    do_reset();
    fetch_en = 1;
    run(8);
    imem_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      check("stall_addr", imem_req_addr, 32'h20);
      check("stall_valid", DW'(imem_req_valid), 1);
      step();
    end
    check("stall_no_alloc", DW'(u_dut.u_queue.alloc_ptr), 0);
    check("stall_empty", DW'(out_valid), 0);
    imem_req_ready = 1;
    step();
    check("stall_accepts", DW'(acc.size()), 9);
    check("stall_accept_addr", acc[8], 32'h20);
    fetch_en = 0;
    run(4);

    do_reset();
    out_ready = 0;
    fetch_en = 1;
    run(4);
    check("ar_buffered_valid", DW'(out_valid), 1);
    check("ar_fill_ptr", DW'(u_dut.u_queue.fill_ptr), 3);
    #3;
    do_reset();
    fetch_en = 1;
    step();
    check("ar_first_req_count", DW'(acc.size()), 1);
    check("ar_first_req_addr", acc[0], 32'h0);
    fetch_en = 0;
    run(3);

    check("sb_drained", DW'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
